regfile_writeback: RTL and testbench

Writeback unit sitting between the execute/memory stages and the write port of the register file. Merges single-cycle ALU results and variable-latency load results (valid/ready) onto the single register-file write port (`RD`, `WriteData`, `RegWrite`). ALU results have priority. Load results that lose arbitration are buffered in a small in-order FIFO. Writes to x0 are discarded at the input.

---
 rtl/regfile_writeback.sv | 149 ++++++++++++++
 tb/tb_regfile_writeback.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - merges ALU and load results onto the register-file write port.
// Optional feature macro: WB_LOAD_BYPASS_EN (lets a load write back directly when the FIFO is empty).
module regfile_writeback #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       alu_valid,
    input  logic [4:0]                 alu_rd,
    input  logic [XLEN-1:0]            alu_data,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [4:0]                 mem_rd,
    input  logic [XLEN-1:0]            mem_data,
    output logic [4:0]                 RD,
    output logic [XLEN-1:0]            WriteData,
    output logic                       RegWrite,
    output logic [$clog2(DEPTH):0]     wb_count,
    output logic                       wb_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = XLEN + 5;

`ifdef WB_LOAD_BYPASS_EN
    localparam logic BYPASS_EN = 1'b1;
`else
    localparam logic BYPASS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_FIFO,
        SRC_BYP
    } src_e;

    logic [EW-1:0]   fifo_mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            regwrite_q, regwrite_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    logic            alu_v;
    logic            load_acc;
    logic            load_nz;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic [EW-1:0]   head;
    src_e            src;

    assign alu_v      = alu_valid && (alu_rd != 5'd0);
    assign fifo_empty = (count_q == '0);
    // Ready looks only at the registered count, so a full FIFO refuses a load even while popping.
    assign mem_ready  = (count_q < CW'(DEPTH));
    assign load_acc   = mem_valid && mem_ready;
    assign load_nz    = load_acc && (mem_rd != 5'd0);
    assign head       = fifo_mem_q[rd_ptr_q];

    always_comb begin
        src = SRC_NONE;
        if (alu_v) begin
            src = SRC_ALU;
        end else if (!fifo_empty) begin
            src = SRC_FIFO;
        end else if (BYPASS_EN && load_nz) begin
            src = SRC_BYP;
        end
    end

    assign push = load_nz && (src != SRC_BYP);
    assign pop  = (src == SRC_FIFO);

    always_comb begin
        regwrite_d = 1'b0;
        rd_d       = rd_q;
        wdata_d    = wdata_q;
        case (src)
            SRC_ALU: begin
                regwrite_d = 1'b1;
                rd_d       = alu_rd;
                wdata_d    = alu_data;
            end
            SRC_FIFO: begin
                regwrite_d = 1'b1;
                rd_d       = head[EW-1:XLEN];
                wdata_d    = head[XLEN-1:0];
            end
            SRC_BYP: begin
                regwrite_d = 1'b1;
                rd_d       = mem_rd;
                wdata_d    = mem_data;
            end
            default: begin
                regwrite_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            regwrite_q <= 1'b0;
            rd_q       <= 5'd0;
            wdata_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            wdata_q    <= wdata_d;
        end
    end

    // Storage needs no reset: entries are only read when the count says they are valid.
    always_ff @(posedge clock) begin
        if (reset_n && push) begin
            fifo_mem_q[wr_ptr_q] <= {mem_rd, mem_data};
        end
    end

    assign RD        = rd_q;
    assign WriteData = wdata_q;
    assign RegWrite  = regwrite_q;
    assign wb_count  = count_q;
    assign wb_busy   = (count_q != '0);

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - directed self-checking bench for regfile_writeback.
module tb_regfile_writeback;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic [4:0]  RD;
    logic [31:0] WriteData;
    logic        RegWrite;
    logic [2:0]  wb_count;
    logic        wb_busy;

    int checks = 0;
    int errors = 0;

    regfile_writeback #(.DEPTH(4), .XLEN(32)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .RD        (RD),
        .WriteData (WriteData),
        .RegWrite  (RegWrite),
        .wb_count  (wb_count),
        .wb_busy   (wb_busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0;
        alu_rd    = 5'd0;
        alu_data  = 32'd0;
        mem_valid = 1'b0;
        mem_rd    = 5'd0;
        mem_data  = 32'd0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        alu_valid = 1'b1;
        alu_rd    = 5'd4;
        alu_data  = 32'hDEAD;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (RegWrite !== 1'b0 || RD !== 5'd0 || WriteData !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: RegWrite=%0b RD=%0d WriteData=%h, expected 0/0/0", RegWrite, RD, WriteData);
        end
        checks++;
        if (wb_count !== 3'd0 || wb_busy !== 1'b0 || mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_status: wb_count=%0d wb_busy=%0b mem_ready=%0b, expected 0/0/1", wb_count, wb_busy, mem_ready);
        end
        idle_inputs();
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        checks++;
        if (RegWrite !== 1'b0 || wb_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_release_idle: RegWrite=%0b wb_count=%0d, expected 0/0", RegWrite, wb_count);
        end
    endtask

    task automatic test_alu();
        alu_valid = 1'b1;
        alu_rd    = 5'd5;
        alu_data  = 32'h1234;
        tick();
        idle_inputs();
        checks++;
        if (RegWrite !== 1'b1 || RD !== 5'd5 || WriteData !== 32'h1234) begin
            errors++;
            $display("FAIL alu_write: RegWrite=%0b RD=%0d WriteData=%h, expected 1/5/00001234", RegWrite, RD, WriteData);
        end
        tick();
        checks++;
        if (RegWrite !== 1'b0 || RD !== 5'd5 || WriteData !== 32'h1234) begin
            errors++;
            $display("FAIL alu_hold: RegWrite=%0b RD=%0d WriteData=%h, expected 0/5/00001234", RegWrite, RD, WriteData);
        end
    endtask

    task automatic test_x0();
        alu_valid = 1'b1;
        alu_rd    = 5'd0;
        alu_data  = 32'hFFFF;
        tick();
        idle_inputs();
        checks++;
        if (RegWrite !== 1'b0 || wb_count !== 3'd0) begin
            errors++;
            $display("FAIL x0_alu: RegWrite=%0b wb_count=%0d, expected 0/0", RegWrite, wb_count);
        end
        mem_valid = 1'b1;
        mem_rd    = 5'd0;
        mem_data  = 32'hBEEF;
        checks++;
        if (mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL x0_load_ready: mem_ready=%0b, expected 1", mem_ready);
        end
        tick();
        idle_inputs();
        checks++;
        if (RegWrite !== 1'b0 || wb_count !== 3'd0) begin
            errors++;
            $display("FAIL x0_load_drop: RegWrite=%0b wb_count=%0d, expected 0/0", RegWrite, wb_count);
        end
        tick();
        checks++;
        if (RegWrite !== 1'b0 || wb_busy !== 1'b0) begin
            errors++;
            $display("FAIL x0_load_late: RegWrite=%0b wb_busy=%0b, expected 0/0", RegWrite, wb_busy);
        end
    endtask

    task automatic test_alu_and_load();
        alu_valid = 1'b1;
        alu_rd    = 5'd3;
        alu_data  = 32'h55;
        mem_valid = 1'b1;
        mem_rd    = 5'd7;
        mem_data  = 32'hAA;
        tick();
        idle_inputs();
        checks++;
        if (RegWrite !== 1'b1 || RD !== 5'd3 || WriteData !== 32'h55 || wb_count !== 3'd1) begin
            errors++;
            $display("FAIL collide_alu_first: RegWrite=%0b RD=%0d WriteData=%h wb_count=%0d, expected 1/3/00000055/1",
                     RegWrite, RD, WriteData, wb_count);
        end
        tick();
        checks++;
        if (RegWrite !== 1'b1 || RD !== 5'd7 || WriteData !== 32'hAA || wb_count !== 3'd0) begin
            errors++;
            $display("FAIL collide_load_second: RegWrite=%0b RD=%0d WriteData=%h wb_count=%0d, expected 1/7/000000aa/0",
                     RegWrite, RD, WriteData, wb_count);
        end
        tick();
    endtask

    task automatic test_fill();
        logic [4:0]  exp_rd [11];
        logic [31:0] exp_wd [11];
        logic [4:0]  got_rd [16];
        logic [31:0] got_wd [16];
        int nw = 0;
        int li = 8;
        int accepts = 0;
        logic acc;
        for (int i = 0; i < 6; i++) begin
            exp_rd[i] = 5'(i + 1);
            exp_wd[i] = 32'h100 + 32'(i + 1);
        end
        for (int i = 0; i < 5; i++) begin
            exp_rd[6 + i] = 5'(8 + i);
            exp_wd[6 + i] = 32'h200 + 32'(8 + i);
        end
        for (int cyc = 0; cyc < 20; cyc++) begin
            alu_valid = (cyc < 6);
            alu_rd    = 5'(cyc + 1);
            alu_data  = 32'h100 + 32'(cyc + 1);
            mem_valid = (li <= 12);
            mem_rd    = 5'(li);
            mem_data  = 32'h200 + 32'(li);
            acc = mem_valid && mem_ready;
            tick();
            if (acc) begin
                li++;
                accepts++;
            end
            if (RegWrite === 1'b1) begin
                if (nw < 16) begin
                    got_rd[nw] = RD;
                    got_wd[nw] = WriteData;
                end
                nw++;
            end
            if (cyc == 5) begin
                checks++;
                if (wb_count !== 3'd4 || mem_ready !== 1'b0 || accepts != 4) begin
                    errors++;
                    $display("FAIL fill_full: wb_count=%0d mem_ready=%0b accepts=%0d, expected 4/0/4", wb_count, mem_ready, accepts);
                end
            end
        end
        idle_inputs();
        checks++;
        if (nw != 11 || wb_count !== 3'd0) begin
            errors++;
            $display("FAIL fill_write_count: writes=%0d wb_count=%0d, expected 11/0", nw, wb_count);
        end else begin
            for (int i = 0; i < 11; i++) begin
                checks++;
                if (got_rd[i] !== exp_rd[i] || got_wd[i] !== exp_wd[i]) begin
                    errors++;
                    $display("FAIL fill_order[%0d]: RD=%0d WriteData=%h, expected %0d/%h", i, got_rd[i], got_wd[i], exp_rd[i], exp_wd[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int nw = 0;
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1;
            alu_rd    = 5'(20 + i);
            alu_data  = 32'(20 + i);
            mem_valid = 1'b1;
            mem_rd    = 5'(24 + i);
            mem_data  = 32'(24 + i);
            tick();
        end
        mem_valid = 1'b0;
        alu_rd    = 5'd30;
        alu_data  = 32'd30;
        tick();
        checks++;
        if (RegWrite !== 1'b1 || wb_count !== 3'd3) begin
            errors++;
            $display("FAIL rstmid_before: RegWrite=%0b wb_count=%0d, expected 1/3", RegWrite, wb_count);
        end
        #2;
        reset_n = 1'b0;
        idle_inputs();
        #1;
        checks++;
        if (RegWrite !== 1'b0 || wb_count !== 3'd0 || wb_busy !== 1'b0 || mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_clear: RegWrite=%0b wb_count=%0d wb_busy=%0b mem_ready=%0b, expected 0/0/0/1",
                     RegWrite, wb_count, wb_busy, mem_ready);
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (RegWrite === 1'b1) nw++;
        end
        checks++;
        if (nw != 0 || wb_count !== 3'd0) begin
            errors++;
            $display("FAIL rstmid_no_ghost: writes=%0d wb_count=%0d, expected 0/0", nw, wb_count);
        end
    endtask

    task automatic test_bypass();
        mem_valid = 1'b1;
        mem_rd    = 5'd9;
        mem_data  = 32'h99;
        tick();
        idle_inputs();
`ifdef WB_LOAD_BYPASS_EN
        checks++;
        if (RegWrite !== 1'b1 || RD !== 5'd9 || WriteData !== 32'h99 || wb_busy !== 1'b0) begin
            errors++;
            $display("FAIL bypass_n1: RegWrite=%0b RD=%0d WriteData=%h wb_busy=%0b, expected 1/9/00000099/0",
                     RegWrite, RD, WriteData, wb_busy);
        end
        tick();
        checks++;
        if (RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL bypass_single: RegWrite=%0b, expected 0", RegWrite);
        end
`else
        checks++;
        if (RegWrite !== 1'b0 || wb_busy !== 1'b1 || wb_count !== 3'd1) begin
            errors++;
            $display("FAIL nobypass_n1: RegWrite=%0b wb_busy=%0b wb_count=%0d, expected 0/1/1", RegWrite, wb_busy, wb_count);
        end
        tick();
        checks++;
        if (RegWrite !== 1'b1 || RD !== 5'd9 || WriteData !== 32'h99 || wb_busy !== 1'b0) begin
            errors++;
            $display("FAIL nobypass_n2: RegWrite=%0b RD=%0d WriteData=%h wb_busy=%0b, expected 1/9/00000099/0",
                     RegWrite, RD, WriteData, wb_busy);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_alu();
        test_x0();
        test_alu_and_load();
        test_fill();
        test_bypass();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
